bsg_sync_channel_sender: RTL

Sender-side controller that shares one clock-domain-crossing channel (a launch/sync/sync synchronizer bank) among `els_p` requesters in the `clk_i` domain. It round-robin arbitrates requesters, launches the winner's data plus tag onto stable channel wires, and toggles a two-phase request bit after a settle interval. It then waits for the receiver's acknowledge toggle, which arrives already synchronized into `clk_i`, before accepting the next transfer. The block sits between local producers and the synchronizer bank feeding the remote domain.

---
 rtl/bsg_sync_channel_sender.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bsg_sync_channel_sender.sv
// bsg_sync_channel_sender
//   Shares one clock-domain-crossing channel among els_p requesters.
//   The block round-robin arbitrates, launches the winner's payload and
//   tag onto held channel wires, and toggles a two-phase request after
//   settle_p cycles. It then waits for the synchronized acknowledge toggle
//   before it accepts the next transfer.
//
// Ports
//   clk_i, reset_i   clock, asynchronous active-high reset
//   v_i, data_i      per-requester valid / payload (requester g at [g*width_p +: width_p])
//   ready_o          one-hot or zero grant; transfer when v_i[g] & ready_o[g]
//   sync_data_o      held payload toward the synchronizer launch flops
//   sync_tag_o       held index of the launched requester
//   sync_req_o       two-phase request toggle
//   ack_sync_i       receiver acknowledge toggle, already in clk_i domain
//   busy_o           state is not IDLE
//   done_o           one-cycle pulse on completion
//   xfer_count_o     completed transfers (wraps)
//   err_o            sticky protocol-error flag
module bsg_sync_channel_sender #(
    parameter int width_p  = 16,
    parameter int els_p    = 2,
    parameter int settle_p = 1,
    localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [els_p-1:0]          v_i,
    input  logic [els_p*width_p-1:0]  data_i,
    output logic [els_p-1:0]          ready_o,
    output logic [width_p-1:0]        sync_data_o,
    output logic [tag_width_lp-1:0]   sync_tag_o,
    output logic                      sync_req_o,
    input  logic                      ack_sync_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               xfer_count_o,
    output logic                      err_o
);
    localparam int cnt_w_lp = (settle_p > 1) ? $clog2(settle_p) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_ACK} state_e;

    state_e                    state_r, state_n;
    logic [tag_width_lp-1:0]   last_r;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic                      ack_r;

    logic                      phase_ok;
    logic                      found;
    logic [tag_width_lp-1:0]   cand;
    logic [tag_width_lp-1:0]   sel_idx;
    logic [els_p-1:0]          grant;
    logic                      accept;
    logic                      err_set;

    assign phase_ok = (ack_sync_i == sync_req_o);

    // Round-robin search starting just above the last winner.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        sel_idx = '0;
        grant   = '0;
        for (int i = 1; i <= els_p; i++) begin
            cand = tag_width_lp'((int'(last_r) + i) % els_p);
            if (!found && v_i[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        for (int g = 0; g < els_p; g++)
            grant[g] = found && (sel_idx == tag_width_lp'(g));
    end

    assign ready_o = (state_r == IDLE && phase_ok) ? grant : '0;
    assign accept  = |ready_o;
    assign busy_o  = (state_r != IDLE);

    // An ack edge outside WAIT_ACK is a protocol error. The exception is an
    // IDLE ack that disagrees with our request phase (stale ack from a far
    // end that was not reset with us); the IDLE hold already covers it.
    assign err_set = (ack_sync_i != ack_r) && (state_r != WAIT_ACK) &&
                     !(state_r == IDLE && !phase_ok);

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:     if (accept) state_n = SETTLE;
            SETTLE:   if (cnt_r == '0) state_n = WAIT_ACK;
            WAIT_ACK: if (phase_ok) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            last_r       <= tag_width_lp'(els_p - 1);
            cnt_r        <= '0;
            ack_r        <= 1'b0;
            sync_data_o  <= '0;
            sync_tag_o   <= '0;
            sync_req_o   <= 1'b0;
            done_o       <= 1'b0;
            xfer_count_o <= '0;
            err_o        <= 1'b0;
        end else begin
            state_r <= state_n;
            ack_r   <= ack_sync_i;
            done_o  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        sync_data_o <= data_i[int'(sel_idx)*width_p +: width_p];
                        sync_tag_o  <= sel_idx;
                        last_r      <= sel_idx;
                        cnt_r       <= cnt_w_lp'(settle_p - 1);
                    end
                end
                SETTLE: begin
                    if (cnt_r == '0) sync_req_o <= ~sync_req_o;
                    else             cnt_r      <= cnt_r - 1'b1;
                end
                WAIT_ACK: begin
                    if (phase_ok) begin
                        done_o       <= 1'b1;
                        xfer_count_o <= xfer_count_o + 16'd1;
                    end
                end
                default: ;
            endcase
            if (err_set) err_o <= 1'b1;
        end
    end
endmodule
